// File: rtl/round_key_store.sv
// Round key store: drives an external key expander through rounds 1..NR after a load request,
// captures each expanded round key into a local register file, and serves any stored round key
// to the cipher datapath with a fixed one-cycle read latency.
module round_key_store #(
  parameter int unsigned NR      = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         load_in,
  input  logic         en_de,
  output logic [127:0] kx_key,
  output logic         kx_start,
  output logic         kx_en_de,
  output logic [3:0]   kx_round,
  input  logic [127:0] kx_key_out,
  input  logic         kx_ready,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         keys_valid,
  output logic         busy,
  output logic         err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LastRound = 4'(NR);
  // Last WAIT count before giving up: the TIMEOUT-th empty WAIT cycle moves to ERR.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StErr} state_e;

  state_e          state_q;
  logic [3:0]      r_q;
  logic [CntW-1:0] cnt_q;
  logic [127:0]    store_q [NR+1];
  logic [127:0]    kx_key_q;
  logic            kx_start_q;
  logic            kx_en_de_q;
  logic [127:0]    rd_key_q;
  logic            keys_valid_q;
  logic            busy_q;
  logic            err_q;

  // Schedule build FSM with registered handshake outputs and key store writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      r_q          <= 4'd0;
      cnt_q        <= '0;
      kx_key_q     <= 128'h0;
      kx_start_q   <= 1'b0;
      kx_en_de_q   <= 1'b0;
      keys_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i <= int'(NR); i++) begin
        store_q[i] <= 128'h0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_in) begin
            kx_key_q     <= key_in;
            store_q[0]   <= key_in;
            kx_en_de_q   <= en_de;
            keys_valid_q <= 1'b0;
            err_q        <= 1'b0;
            r_q          <= 4'd1;
            busy_q       <= 1'b1;
            kx_start_q   <= 1'b1;
            state_q      <= StReq;
          end
        end
        StReq: begin
          // Any kx_ready seen here is stale from the previous round and is ignored.
          kx_start_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (kx_ready) begin
            store_q[r_q] <= kx_key_out;
            if (r_q == LastRound) begin
              state_q <= StDone;
            end else begin
              r_q        <= r_q + 4'd1;
              kx_start_q <= 1'b1;
              state_q    <= StReq;
            end
          end else if (cnt_q == CntLast) begin
            state_q <= StErr;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          keys_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        StErr: begin
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read port: one-cycle latency, zero for out-of-range index or incomplete schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key_q <= 128'h0;
    end else if (keys_valid_q && (rd_round <= LastRound)) begin
      rd_key_q <= store_q[rd_round];
    end else begin
      rd_key_q <= 128'h0;
    end
  end

  assign kx_key     = kx_key_q;
  assign kx_start   = kx_start_q;
  assign kx_en_de   = kx_en_de_q;
  assign kx_round   = r_q;
  assign rd_key     = rd_key_q;
  assign keys_valid = keys_valid_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
